// File: rtl/dcache_assoc_ctrl_if.sv
// dcache_assoc_ctrl_if: bundles the load/store request side and the memory port of the associative data cache
// master drives rd/wr requests and memory responses (data_mem, mem_ack); slave is the cache controller
interface dcache_assoc_ctrl_if #(
  parameter int BLOCK_SIZE = 10,
  parameter int DATA_SIZE  = 32,
  parameter int WAYS       = 4
);
  localparam int WAY_BITS = $clog2(WAYS);
  logic [BLOCK_SIZE-1:0] rd_addr;
  logic                  rd_en;
  logic [BLOCK_SIZE-1:0] wr_addr;
  logic [DATA_SIZE-1:0]  wr_data;
  logic                  wr_en;
  logic [DATA_SIZE-1:0]  data;
  logic                  valid;
  logic                  busy;
  logic [WAY_BITS-1:0]   set_offset_out;
  logic [BLOCK_SIZE-1:0] rd_addr_mem;
  logic                  rd_en_mem;
  logic [BLOCK_SIZE-1:0] wr_addr_mem;
  logic [DATA_SIZE-1:0]  wr_data_mem;
  logic                  wr_en_mem;
  logic [DATA_SIZE-1:0]  data_mem;
  logic                  mem_ack;
  modport master (
    output rd_addr, rd_en, wr_addr, wr_data, wr_en, data_mem, mem_ack,
    input  data, valid, busy, set_offset_out, rd_addr_mem, rd_en_mem, wr_addr_mem, wr_data_mem, wr_en_mem
  );
  modport slave (
    input  rd_addr, rd_en, wr_addr, wr_data, wr_en, data_mem, mem_ack,
    output data, valid, busy, set_offset_out, rd_addr_mem, rd_en_mem, wr_addr_mem, wr_data_mem, wr_en_mem
  );
endinterface

// File: rtl/dcache_assoc_ctrl.sv
// dcache_assoc_ctrl: N-way set-associative write-through, no-write-allocate data cache controller with per-set round-robin replacement
// ports: clk, rst (async, active-high), bus (slave side of dcache_assoc_ctrl_if: request/response to LSU, req/ack to memory)
module dcache_assoc_ctrl #(
  parameter int BLOCK_SIZE = 10,
  parameter int DATA_SIZE  = 32,
  parameter int INDEX_SIZE = 3,
  parameter int WAYS       = 4
) (
  input logic clk,
  input logic rst,
  dcache_assoc_ctrl_if.slave bus
);
  localparam int SETS     = 2 ** INDEX_SIZE;
  localparam int TAG_SIZE = BLOCK_SIZE - INDEX_SIZE;
  localparam int WAY_BITS = $clog2(WAYS);
  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} stateT;
  stateT state, nextState;
  logic [DATA_SIZE-1:0] dataArr [SETS][WAYS];
  logic [TAG_SIZE-1:0]  tagArr  [SETS][WAYS];
  logic [WAYS-1:0]      validArr [SETS];
  logic [WAY_BITS-1:0]  rrPtr [SETS];
  logic [INDEX_SIZE-1:0] rdIdx, wrIdx, missIdx;
  logic [TAG_SIZE-1:0]   rdTag, wrTag, missTag;
  logic rdHit, wrHit, allValid, accRd, accWr, fill;
  logic [WAY_BITS-1:0] rdWay, wrWay, victim;
  logic [DATA_SIZE-1:0] nData, nWrDataMem;
  logic [BLOCK_SIZE-1:0] nRdAddrMem, nWrAddrMem;
  logic [WAY_BITS-1:0] nWay;
  logic nValid;
  assign rdIdx   = bus.rd_addr[INDEX_SIZE-1:0];
  assign rdTag   = bus.rd_addr[BLOCK_SIZE-1:INDEX_SIZE];
  assign wrIdx   = bus.wr_addr[INDEX_SIZE-1:0];
  assign wrTag   = bus.wr_addr[BLOCK_SIZE-1:INDEX_SIZE];
  // the pending miss address is held on rd_addr_mem, so the fill set/tag come from there
  assign missIdx = bus.rd_addr_mem[INDEX_SIZE-1:0];
  assign missTag = bus.rd_addr_mem[BLOCK_SIZE-1:INDEX_SIZE];
  assign accWr   = state == IDLE && bus.wr_en;
  assign accRd   = state == IDLE && bus.rd_en && !bus.wr_en;
  assign fill    = state == RD_MISS && bus.mem_ack;
  // descending scan so the lowest-numbered matching/invalid way wins
  always_comb begin
    rdHit = 1'b0;
    rdWay = '0;
    wrHit = 1'b0;
    wrWay = '0;
    allValid = 1'b1;
    victim = rrPtr[missIdx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (validArr[rdIdx][w] && tagArr[rdIdx][w] == rdTag) begin
        rdHit = 1'b1;
        rdWay = WAY_BITS'(w);
      end
      if (validArr[wrIdx][w] && tagArr[wrIdx][w] == wrTag) begin
        wrHit = 1'b1;
        wrWay = WAY_BITS'(w);
      end
      if (!validArr[missIdx][w]) begin
        allValid = 1'b0;
        victim = WAY_BITS'(w);
      end
    end
  end
  always_comb begin
    nextState = state;
    if (state == IDLE)
      nextState = accWr ? WR_THRU : (accRd && !rdHit) ? RD_MISS : IDLE;
    else if (bus.mem_ack)
      nextState = IDLE;
  end
  always_comb begin
    nValid     = (accRd && rdHit) || fill;
    nData      = (accRd && rdHit) ? dataArr[rdIdx][rdWay] : fill ? bus.data_mem : bus.data;
    nWay       = (accRd && rdHit) ? rdWay : fill ? victim : bus.set_offset_out;
    nRdAddrMem = (accRd && !rdHit) ? bus.rd_addr : bus.rd_addr_mem;
    nWrAddrMem = accWr ? bus.wr_addr : bus.wr_addr_mem;
    nWrDataMem = accWr ? bus.wr_data : bus.wr_data_mem;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      bus.data           <= '0;
      bus.valid          <= 1'b0;
      bus.busy           <= 1'b0;
      bus.set_offset_out <= '0;
      bus.rd_addr_mem    <= '0;
      bus.rd_en_mem      <= 1'b0;
      bus.wr_addr_mem    <= '0;
      bus.wr_data_mem    <= '0;
      bus.wr_en_mem      <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        validArr[s] <= '0;
        rrPtr[s]    <= '0;
      end
    end else begin
      state              <= nextState;
      bus.data           <= nData;
      bus.valid          <= nValid;
      bus.busy           <= nextState != IDLE;
      bus.set_offset_out <= nWay;
      bus.rd_addr_mem    <= nRdAddrMem;
      bus.rd_en_mem      <= nextState == RD_MISS;
      bus.wr_addr_mem    <= nWrAddrMem;
      bus.wr_data_mem    <= nWrDataMem;
      bus.wr_en_mem      <= nextState == WR_THRU;
      if (fill) begin
        validArr[missIdx][victim] <= 1'b1;
        if (allValid) rrPtr[missIdx] <= rrPtr[missIdx] + WAY_BITS'(1);
      end
    end
  end
  // payload arrays carry no reset; validArr alone decides whether their contents count
  always_ff @(posedge clk) begin
    if (fill) begin
      dataArr[missIdx][victim] <= bus.data_mem;
      tagArr[missIdx][victim]  <= missTag;
    end
    if (accWr && wrHit) dataArr[wrIdx][wrWay] <= bus.wr_data;
  end
endmodule

// File: tb/tb_dcache_assoc_ctrl.sv
// tb_dcache_assoc_ctrl: directed self-checking bench for dcache_assoc_ctrl
module tb_dcache_assoc_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  dcache_assoc_ctrl_if #(.BLOCK_SIZE(10), .DATA_SIZE(32), .WAYS(4)) bus ();
  dcache_assoc_ctrl #(.BLOCK_SIZE(10), .DATA_SIZE(32), .INDEX_SIZE(3), .WAYS(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic readMiss(input logic [9:0] a, input logic [31:0] d, input int w, input int dly);
    @(negedge clk);
    bus.rd_addr = a;
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    for (int i = 0; i < dly; i++) begin
      check("missReq", bus.rd_en_mem, 1);
      check("missBusy", bus.busy, 1);
      if (i == 0) check("missAddr", bus.rd_addr_mem, a);
      if (i == dly - 1) begin
        bus.mem_ack = 1'b1;
        bus.data_mem = d;
      end
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
    check("fillValid", bus.valid, 1);
    check("fillData", bus.data, d);
    check("fillWay", bus.set_offset_out, w);
    check("fillReqDrop", bus.rd_en_mem, 0);
    check("fillBusy", bus.busy, 0);
  endtask
  task automatic readHit(input logic [9:0] a, input logic [31:0] d, input int w);
    @(negedge clk);
    bus.rd_addr = a;
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check("hitValid", bus.valid, 1);
    check("hitData", bus.data, d);
    check("hitWay", bus.set_offset_out, w);
    check("hitNoMem", bus.rd_en_mem, 0);
    check("hitBusy", bus.busy, 0);
  endtask
  task automatic writeOp(input logic [9:0] a, input logic [31:0] d, input int dly);
    @(negedge clk);
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
    for (int i = 0; i < dly; i++) begin
      check("wrReq", bus.wr_en_mem, 1);
      check("wrBusy", bus.busy, 1);
      check("wrNoValid", bus.valid, 0);
      if (i == 0) begin
        check("wrAddr", bus.wr_addr_mem, a);
        check("wrData", bus.wr_data_mem, d);
      end
      if (i == dly - 1) bus.mem_ack = 1'b1;
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
    check("wrDone", bus.wr_en_mem, 0);
    check("wrDoneBusy", bus.busy, 0);
    check("wrDoneValid", bus.valid, 0);
  endtask
  initial begin
    logic [9:0] streak [4];
    streak = '{10'h000, 10'h008, 10'h010, 10'h018};
    bus.rd_addr = '0;
    bus.rd_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_en = 1'b0;
    bus.data_mem = '0;
    bus.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rstValid", bus.valid, 0);
    check("rstBusy", bus.busy, 0);
    check("rstRdEnMem", bus.rd_en_mem, 0);
    check("rstWrEnMem", bus.wr_en_mem, 0);
    check("rstData", bus.data, 0);
    rst = 1'b0;
    // ack while idle must do nothing
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("idleAckValid", bus.valid, 0);
    check("idleAckBusy", bus.busy, 0);
    readMiss(10'h004, 32'hDEADBEEF, 0, 3);
    readHit(10'h004, 32'hDEADBEEF, 0);
    @(negedge clk);
    check("pulseEnd", bus.valid, 0);
    check("dataHold", bus.data, 32'hDEADBEEF);
    readMiss(10'h000, 32'hA0000000, 0, 1);
    readMiss(10'h008, 32'hA0000008, 1, 2);
    readMiss(10'h010, 32'hA0000010, 2, 1);
    readMiss(10'h018, 32'hA0000018, 3, 1);
    readMiss(10'h020, 32'hA0000020, 0, 1);
    readMiss(10'h000, 32'hB0000000, 1, 1);
    readMiss(10'h008, 32'hB0000008, 2, 1);
    writeOp(10'h004, 32'h12345678, 2);
    readHit(10'h004, 32'h12345678, 0);
    writeOp(10'h00C, 32'hCAFEF00D, 1);
    readMiss(10'h00C, 32'h0BADF00D, 1, 1);
    @(negedge clk);
    bus.rd_addr = 10'h004;
    bus.rd_en = 1'b1;
    bus.wr_addr = 10'h00C;
    bus.wr_data = 32'h55AA55AA;
    bus.wr_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    check("bothWr", bus.wr_en_mem, 1);
    check("bothNoRd", bus.rd_en_mem, 0);
    check("bothNoValid", bus.valid, 0);
    check("bothAddr", bus.wr_addr_mem, 10'h00C);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("bothDone", bus.wr_en_mem, 0);
    readHit(10'h00C, 32'h55AA55AA, 1);
    @(negedge clk);
    bus.rd_addr = 10'h014;
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check("abortReq", bus.rd_en_mem, 1);
    #2 rst = 1'b1;
    #1;
    check("abortRdEnMem", bus.rd_en_mem, 0);
    check("abortBusy", bus.busy, 0);
    check("abortAddr", bus.rd_addr_mem, 0);
    check("abortData", bus.data, 0);
    check("abortWay", bus.set_offset_out, 0);
    @(negedge clk);
    rst = 1'b0;
    readMiss(10'h004, 32'h11112222, 0, 2);
    for (int i = 0; i < 4; i++) readMiss(streak[i], 32'hC0 + i, i, 1);
    @(negedge clk);
    bus.rd_addr = streak[0];
    bus.rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("streakValid", bus.valid, 1);
      check("streakData", bus.data, 32'hC0 + i);
      check("streakWay", bus.set_offset_out, i);
      check("streakBusy", bus.busy, 0);
      if (i < 3) bus.rd_addr = streak[i+1];
      else bus.rd_en = 1'b0;
    end
    @(negedge clk);
    check("streakEnd", bus.valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
